// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data RAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking instead of fixed priority.
module ram_arbiter #(
    parameter int DWIDTH      = 32,
    parameter bit P0_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    input  logic [2:0]        m0_func3,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    input  logic [2:0]        m1_func3,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic              m1_err,
    output logic              ram_rdEn,
    output logic              ram_wrEn,
    output logic [DWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wr_data,
    output logic              ram_isByte,
    output logic              ram_isHalf,
    output logic              ram_isWord,
    output logic [2:0]        ram_func3,
    input  logic [DWIDTH-1:0] ram_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              mis_q, mis_d;

    logic              m0_gnt_q, m0_gnt_d;
    logic              m1_gnt_q, m1_gnt_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic              m0_err_q, m0_err_d;
    logic              m1_err_q, m1_err_d;
    logic [DWIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DWIDTH-1:0] m1_rdata_q, m1_rdata_d;

    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              is_byte_q, is_byte_d;
    logic              is_half_q, is_half_d;
    logic              is_word_q, is_word_d;
    logic [2:0]        func3_q, func3_d;

    logic              any_req;
    logic              tie_win;
    logic              win;
    logic              sel_we;
    logic [DWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;
    logic [2:0]        sel_func3;
    logic              sel_mis;

`ifdef RAM_ARB_RR_EN
    // Pointer holds the last granted port; reset value makes port 0 win first.
    logic last_q, last_d;

    assign tie_win = ~last_q;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && any_req) begin
            last_d = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign tie_win = ~P0_PRIORITY;
`endif

    assign any_req = m0_req | m1_req;

    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) begin
            win = tie_win;
        end else if (m1_req) begin
            win = 1'b1;
        end
    end

    assign sel_we    = win ? m1_we    : m0_we;
    assign sel_addr  = win ? m1_addr  : m0_addr;
    assign sel_wdata = win ? m1_wdata : m0_wdata;
    assign sel_func3 = win ? m1_func3 : m0_func3;

    assign sel_mis = ((sel_func3[1:0] == 2'd1) && sel_addr[0]) ||
                     ((sel_func3[1:0] == 2'd2) && (sel_addr[1:0] != 2'd0));

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        mis_d       = mis_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_err_d    = 1'b0;
        m1_err_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_byte_d   = is_byte_q;
        is_half_d   = is_half_q;
        is_word_d   = is_word_q;
        func3_d     = func3_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    port_d    = win;
                    we_d      = sel_we;
                    mis_d     = sel_mis;
                    m0_gnt_d  = ~win;
                    m1_gnt_d  = win;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    func3_d   = sel_func3;
                    is_byte_d = (sel_func3[1:0] == 2'd0);
                    is_half_d = (sel_func3[1:0] == 2'd1);
                    is_word_d = (sel_func3[1:0] == 2'd2);
                    rd_en_d   = ~sel_we & ~sel_mis;
                    wr_en_d   = sel_we & ~sel_mis;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // Misaligned stores still report back through RESP.
                if (!we_q || mis_q) begin
                    state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (port_q) begin
                    m1_rvalid_d = 1'b1;
                    m1_err_d    = mis_q;
                    m1_rdata_d  = mis_q ? '0 : ram_rd_data;
                end else begin
                    m0_rvalid_d = 1'b1;
                    m0_err_d    = mis_q;
                    m0_rdata_d  = mis_q ? '0 : ram_rd_data;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_byte_q   <= 1'b0;
            is_half_q   <= 1'b0;
            is_word_q   <= 1'b0;
            func3_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            mis_q       <= mis_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_err_q    <= m0_err_d;
            m1_err_q    <= m1_err_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_byte_q   <= is_byte_d;
            is_half_q   <= is_half_d;
            is_word_q   <= is_word_d;
            func3_q     <= func3_d;
        end
    end

    assign m0_gnt      = m0_gnt_q;
    assign m1_gnt      = m1_gnt_q;
    assign m0_rvalid   = m0_rvalid_q;
    assign m1_rvalid   = m1_rvalid_q;
    assign m0_err      = m0_err_q;
    assign m1_err      = m1_err_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign ram_rdEn    = rd_en_q;
    assign ram_wrEn    = wr_en_q;
    assign ram_addr    = addr_q;
    assign ram_wr_data = wdata_q;
    assign ram_isByte  = is_byte_q;
    assign ram_isHalf  = is_half_q;
    assign ram_isWord  = is_word_q;
    assign ram_func3   = func3_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, hand sequences and random traffic
// against a byte-array memory model.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_func3, m1_func3;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_rdEn, ram_wrEn;
    logic [31:0] ram_addr, ram_wr_data;
    logic        ram_isByte, ram_isHalf, ram_isWord;
    logic [2:0]  ram_func3;
    logic [31:0] ram_rd_data = '0;

    int total = 0;
    int bad   = 0;

    ram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_func3   (m0_func3),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m0_err     (m0_err),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_func3   (m1_func3),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .m1_err     (m1_err),
        .ram_rdEn   (ram_rdEn),
        .ram_wrEn   (ram_wrEn),
        .ram_addr   (ram_addr),
        .ram_wr_data(ram_wr_data),
        .ram_isByte (ram_isByte),
        .ram_isHalf (ram_isHalf),
        .ram_isWord (ram_isWord),
        .ram_func3  (ram_func3),
        .ram_rd_data(ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic any_out;
    assign any_out = |{m0_gnt, m0_rvalid, m0_rdata, m0_err,
                       m1_gnt, m1_rvalid, m1_rdata, m1_err,
                       ram_rdEn, ram_wrEn, ram_addr, ram_wr_data,
                       ram_isByte, ram_isHalf, ram_isWord, ram_func3};

    // RAM behaviour: little-endian bytes, registered read with sign handling
    logic [7:0] mem [0:255];
    logic       mem_ready = 1'b0;

    function automatic logic [31:0] ram_rd(input logic [7:0] a, input logic bb,
                                           input logic hh, input logic [2:0] f3);
        logic [7:0]  b0, b1;
        logic [31:0] r;
        if (bb) begin
            b0 = mem[a];
            r = f3[2] ? {24'd0, b0} : {{24{b0[7]}}, b0};
        end else if (hh) begin
            b0 = mem[{a[7:1], 1'b0}];
            b1 = mem[{a[7:1], 1'b1}];
            r = f3[2] ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
        end else begin
            r = {mem[{a[7:2], 2'd3}], mem[{a[7:2], 2'd2}],
                 mem[{a[7:2], 2'd1}], mem[{a[7:2], 2'd0}]};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_ready <= 1'b1;
        end else begin
            if (ram_wrEn) begin
                if (ram_isByte) begin
                    mem[ram_addr[7:0]] <= ram_wr_data[7:0];
                end else if (ram_isHalf) begin
                    mem[{ram_addr[7:1], 1'b0}] <= ram_wr_data[7:0];
                    mem[{ram_addr[7:1], 1'b1}] <= ram_wr_data[15:8];
                end else begin
                    for (int i = 0; i < 4; i++)
                        mem[{ram_addr[7:2], 2'(i)}] <= ram_wr_data[8*i +: 8];
                end
            end
            if (ram_rdEn)
                ram_rd_data <= ram_rd(ram_addr[7:0], ram_isByte, ram_isHalf, ram_func3);
        end
    end

    // Reference memory: what the RAM should hold after the granted stores
    logic [7:0] ref_mem [0:255];

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        return (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int n, base;
        logic [31:0] v;
        n = size_of(f3);
        base = int'(a[7:0]) & ~(n - 1);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n, base;
        n = size_of(f3);
        base = int'(a[7:0]) & ~(n - 1);
        for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wd >> (8 * i));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit p, input bit v, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        if (!p) begin
            m0_req = v; m0_we = we; m0_func3 = f3; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = v; m1_we = we; m1_func3 = f3; m1_addr = a; m1_wdata = wd;
        end
    endtask

    // One full transaction from an idle arbiter, called at a negedge
    task automatic do_op(input bit p, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        bit mis, got;
        int cyc;
        mis = is_mis(f3, a);
        rd = '0; er = 1'b0; got = 0; cyc = 0;
        set_req(p, 1, we, f3, a, wd);
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (p ? m1_gnt : m0_gnt) got = 1;
        end
        chk("gnt_cycle", cyc, 1);
        set_req(p, 0, 0, 3'd0, '0, '0);
        if (got) begin
            chk("other_gnt", p ? m0_gnt : m1_gnt, 0);
            chk("ram_ctl",
                {ram_rdEn, ram_wrEn, ram_isByte, ram_isHalf, ram_isWord, ram_func3},
                {!we && !mis, we && !mis, f3[1:0] == 2'd0, f3[1:0] == 2'd1,
                 f3[1:0] == 2'd2, f3});
            chk("ram_addr", ram_addr, a);
            if (we) chk("ram_wdata", ram_wr_data, wd);
            if (we && !mis) ref_store(f3, a, wd);
            @(negedge clk);
            chk("one_cycle", {m0_gnt, m1_gnt, ram_rdEn, ram_wrEn, m0_rvalid, m1_rvalid}, 0);
            @(negedge clk);
            chk("rvalid", p ? m1_rvalid : m0_rvalid, (!we || mis));
            chk("rvalid_other", p ? m0_rvalid : m1_rvalid, 0);
            rd = p ? m1_rdata : m0_rdata;
            er = p ? m1_err : m0_err;
            @(negedge clk);
            chk("rvalid_pulse", m0_rvalid | m1_rvalid, 0);
        end
    endtask

    typedef struct {
        bit          p;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          resp;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [31:0] rd, e0, e1;
        logic        er;
        int          g0, g1, ovl, n, r0, r1;
        int          ord [4];
        int          exp_ord [4];

        vt[0]  = '{0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0};
        vt[1]  = '{0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1};
        vt[2]  = '{0, 1, 3'b000, 32'h20, 32'h000000F0, 32'h0,        0, 0};
        vt[3]  = '{0, 0, 3'b000, 32'h20, 32'h0,        32'hFFFFFFF0, 0, 1};
        vt[4]  = '{0, 0, 3'b100, 32'h20, 32'h0,        32'h000000F0, 0, 1};
        vt[5]  = '{1, 0, 3'b001, 32'h21, 32'h0,        32'h0,        1, 1};
        vt[6]  = '{1, 1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0,        0, 0};
        vt[7]  = '{1, 0, 3'b101, 32'h22, 32'h0,        32'h0000ABCD, 0, 1};
        vt[8]  = '{1, 0, 3'b001, 32'h22, 32'h0,        32'hFFFFABCD, 0, 1};
        vt[9]  = '{0, 1, 3'b010, 32'h13, 32'h0BADF00D, 32'h0,        1, 1};
        vt[10] = '{1, 0, 3'b011, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1};
        vt[11] = '{0, 0, 3'b010, 32'h20, 32'h0,        32'hABCD7BF0, 0, 1};
        vt[12] = '{0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 1};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        rst_n = 1'b0;
        set_req(0, 0, 0, 3'd0, '0, '0);
        set_req(1, 0, 0, 3'd0, '0, '0);
        repeat (3) @(negedge clk);
        chk("reset_outs", any_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_op(vt[i].p, vt[i].we, vt[i].f3, vt[i].a, vt[i].wd, rd, er);
            if (vt[i].resp) begin
                chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
                chk($sformatf("vec%0d_err", i), er, vt[i].exp_err);
            end
        end

        // Held store request: second grant two cycles after the first
        set_req(0, 1, 1, 3'b010, 32'h40, 32'hA5A5_0001);
        @(negedge clk);
        chk("b2b_gnt1", {m0_gnt, ram_wrEn}, 2'b11);
        ref_store(3'b010, 32'h40, 32'hA5A5_0001);
        set_req(0, 1, 1, 3'b010, 32'h44, 32'hA5A5_0002);
        @(negedge clk);
        chk("b2b_gap", {m0_gnt, ram_wrEn}, 2'b00);
        @(negedge clk);
        chk("b2b_gnt2", {m0_gnt, ram_wrEn}, 2'b11);
        chk("b2b_addr2", ram_addr, 32'h44);
        ref_store(3'b010, 32'h44, 32'hA5A5_0002);
        set_req(0, 0, 0, 3'd0, '0, '0);
        repeat (2) @(negedge clk);
        do_op(1, 0, 3'b010, 32'h44, '0, rd, er);
        chk("b2b_rd", rd, 32'hA5A5_0002);

        // Simultaneous loads after a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e0 = ref_load(3'b010, 32'h10);
        e1 = ref_load(3'b010, 32'h20);
        set_req(0, 1, 0, 3'b010, 32'h10, '0);
        set_req(1, 1, 0, 3'b010, 32'h20, '0);
        g0 = -1; g1 = -1; ovl = 0; r0 = 0; r1 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if ((m0_gnt && m1_gnt) || (ram_rdEn && ram_wrEn)) ovl++;
            if (m0_gnt) begin g0 = c; set_req(0, 0, 0, 3'd0, '0, '0); end
            if (m1_gnt) begin g1 = c; set_req(1, 0, 0, 3'd0, '0, '0); end
            if (m0_rvalid) begin r0++; chk("tie_rdata0", m0_rdata, e0); end
            if (m1_rvalid) begin r1++; chk("tie_rdata1", m1_rdata, e1); end
        end
        chk("tie_first", g0, 1);
        chk("tie_second", g1, 4);
        chk("tie_overlap", ovl, 0);
        chk("tie_rvalids", {r0[15:0], r1[15:0]}, {16'd1, 16'd1});

        // Both held across four grants
`ifdef RAM_ARB_RR_EN
        exp_ord = '{0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 0, 0};
`endif
        set_req(0, 1, 0, 3'b010, 32'h10, '0);
        set_req(1, 1, 0, 3'b010, 32'h20, '0);
        n = 0; ovl = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (m0_gnt && m1_gnt) ovl++;
            if (m0_gnt) begin ord[n] = 0; n++; end
            else if (m1_gnt) begin ord[n] = 1; n++; end
        end
        set_req(0, 0, 0, 3'd0, '0, '0);
        set_req(1, 0, 0, 3'd0, '0, '0);
        chk("arb4_count", n, 4);
        chk("arb4_overlap", ovl, 0);
        for (int i = 0; i < 4 && i < n; i++)
            chk($sformatf("arb4_order%0d", i), ord[i], exp_ord[i]);
        repeat (4) @(negedge clk);

        // Reset during the RAM cycle of a store
        do_op(0, 1, 3'b010, 32'h30, 32'h11223344, rd, er);
        set_req(0, 1, 1, 3'b010, 32'h30, 32'h55AA55AA);
        @(negedge clk);
        chk("rst_pre_wr", {m0_gnt, ram_wrEn}, 2'b11);
        set_req(0, 0, 0, 3'd0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", any_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(0, 0, 3'b010, 32'h30, '0, rd, er);
        chk("rst_mem_kept", rd, 32'h11223344);

        // Random traffic against the reference memory
        for (int k = 0; k < 60; k++) begin
            bit          p, we, mis;
            logic [2:0]  f3;
            logic [31:0] a, wd, exp;
            int          li;
            p  = 1'($urandom % 2);
            we = 1'($urandom % 2);
            a  = 32'($urandom % 256);
            wd = $urandom;
            if (we) begin
                f3 = {1'b0, 2'($urandom % 3)};
            end else begin
                li = $urandom % 5;
                f3 = (li < 3) ? 3'(li) : 3'(li + 1);
                if ($urandom % 8 == 0) begin
                    f3 = 3'b011;
                    a = a & ~32'd3;
                end
            end
            mis = is_mis(f3, a);
            exp = mis ? 32'd0 : ref_load(f3, a);
            do_op(p, we, f3, a, wd, rd, er);
            if (mis || !we) begin
                chk($sformatf("rnd%0d_rdata", k), rd, exp);
                chk($sformatf("rnd%0d_err", k), er, mis);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data RAM.
- Port 0 is the load/store unit; port 1 is instruction fetch or a debug loader.
- Accepts one request at a time, drives the RAM control signals (rdEn, wrEn, addr, wr_data, isByte/isHalf/isWord, func3) for one cycle, and returns read data with a valid pulse.
- Serialises all RAM traffic so the RAM never sees simultaneous requesters.

Parameters:
- DWIDTH, 32, data and address width.
- P0_PRIORITY, 1, fixed-priority mode only: 1 means port 0 wins ties, 0 means port 1 wins ties.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  port 0 request; held until m0_gnt is seen.
- m0_we  input  1  port 0: 1 = store, 0 = load.
- m0_addr  input  DWIDTH  port 0 byte address.
- m0_wdata  input  DWIDTH  port 0 store data.
- m0_func3  input  3  port 0 RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- m0_gnt  output  1  port 0 grant, one-cycle pulse.
- m0_rvalid  output  1  port 0 read data valid, one-cycle pulse.
- m0_rdata  output  DWIDTH  port 0 read data.
- m0_err  output  1  port 0 misaligned-access error, pulses with rvalid.
- m1_*  same set as m0_*, for port 1.
- ram_rdEn  output  1  RAM read enable.
- ram_wrEn  output  1  RAM write enable.
- ram_addr  output  DWIDTH  RAM address.
- ram_wr_data  output  DWIDTH  RAM write data.
- ram_isByte  output  1  RAM byte access flag.
- ram_isHalf  output  1  RAM half-word access flag.
- ram_isWord  output  1  RAM word access flag.
- ram_func3  output  3  RAM funct3 pass-through.
- ram_rd_data  input  DWIDTH  RAM registered read data.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n. The state machine uses three states: IDLE, ACCESS, RESP.
- Reset: state = IDLE. Every output is forced to 0 immediately on rst_n low, including ram_wrEn, so no write can land during reset. The round-robin pointer resets to favour port 0.
- All outputs are registered.
- IDLE: requests are sampled only in this state.
  - If any mN_req is high at edge E0, arbitrate and latch we/addr/wdata/func3 of the winner.
  - Set mN_gnt = 1 for the winner only.
  - Load ram_* with the latched command. ram_rdEn = !we, ram_wrEn = we.
  - Size flags: ram_isByte = (func3[1:0] == 0), ram_isHalf = (func3[1:0] == 1), ram_isWord = (func3[1:0] == 2).
  - Go to ACCESS.
- ACCESS (cycle 1): the RAM performs the operation at E1.
  - At E1: clear gnt, ram_rdEn and ram_wrEn. Hold ram_addr, ram_wr_data and the flags (don't-care).
  - Read: go to RESP. Write: go to IDLE.
- RESP (cycle 2): ram_rd_data is valid.
  - At E2: mN_rdata <= ram_rd_data, mN_rvalid <= 1 (port latched at E0). Go to IDLE.
  - rvalid and rdata are high during cycle 3 only; rdata holds its value until the next read for that port.
- Timing:
  - Read latency, req sampled to rvalid: 3 cycles.
  - Throughput: one read per 3 cycles, one write per 2 cycles.
  - Writes return no response; gnt is the acknowledgement.
- Requester rule: drop req in the cycle after gnt is seen, or keep it high to issue a back-to-back request. Req is ignored outside IDLE.
- Fixed priority (default build): on a tie, the winner is port 0 when P0_PRIORITY = 1, otherwise port 1. A lone requester always wins.
- Misalignment: half access with addr[0] = 1, or word access with addr[1:0] != 0.
  - No RAM enable is asserted; ram_rdEn and ram_wrEn stay 0.
  - Go IDLE -> ACCESS -> RESP as normal.
  - In RESP: mN_rvalid = 1, mN_err = 1, mN_rdata = 0. This applies to stores as well.
- func3[1:0] = 3: no size flag is set, so the RAM performs a full-word access. This is not flagged as an error.
- Reset mid-operation: any outstanding rvalid or gnt is lost and the state returns to IDLE. Requesters must re-issue.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin arbitration on ties. A 1-bit last-grant pointer is updated on each grant; on a tie the port not granted last wins, and P0_PRIORITY is ignored. A lone requester always wins.
- Undefined: fixed priority per P0_PRIORITY, and no pointer register exists.

Test Plan:
- Reset, then m0 SW addr 0x10 data 0xDEADBEEF, then m0 LW 0x10 -> write: m0_gnt pulse, ram_wrEn high for exactly 1 cycle. Read: m0_rvalid 3 cycles after req, m0_rdata = 0xDEADBEEF, m0_err = 0.
- m0 SB 0x20 data 0x000000F0, then LB 0x20 -> rdata 0xFFFFFFF0. Then LBU 0x20 -> rdata 0x000000F0.
- m0 and m1 both request LW in the same cycle, held, default build -> m0 granted first, m1 granted on the next IDLE cycle, no overlapping ram enables. With RAM_ARB_RR_EN defined -> grants alternate m0, m1, m0, m1 across 4 requests.
- m1 LH addr 0x21 -> no ram_rdEn. m1_rvalid = 1, m1_err = 1, m1_rdata = 0 in cycle 3.
- rst_n low during ACCESS of an SW to 0x30 -> ram_wrEn drops to 0 immediately, all outputs 0. After release, LW 0x30 returns the prior contents.
